// File: rtl/seg7_word_reader_if.sv
// seg7_word_reader_if
//   Glyph stream in, assembled hex word out, for seg7_word_reader.
//   NUM_DIGITS must match the reader's NUM_DIGITS (sets the width of value).
//   master : glyph producer / word consumer
//            drives seg_in, seg_valid, flush, value_ready
//   slave  : the reader
//            drives seg_ready, value, value_err, value_valid, digit_cnt
interface seg7_word_reader_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  logic [6:0]              seg_in;
  logic                    seg_valid;
  logic                    seg_ready;
  logic                    flush;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_err;
  logic                    value_valid;
  logic                    value_ready;
  logic [3:0]              digit_cnt;

  modport master (
    output seg_in, seg_valid, flush, value_ready,
    input  seg_ready, value, value_err, value_valid, digit_cnt
  );

  modport slave (
    input  seg_in, seg_valid, flush, value_ready,
    output seg_ready, value, value_err, value_valid, digit_cnt
  );
endinterface

// File: rtl/seg7_word_reader.sv
// seg7_word_reader
//   Inverse 7-segment decoder. Takes a stream of active-low glyphs
//   (bit0=a .. bit6=g, 0 = lit), MS digit first, and rebuilds a hex word of
//   NUM_DIGITS nibbles. Any glyph that is not a hex pattern decodes to 0 and
//   flags value_err for that word.
//   Ports:
//     clock   : system clock, rising edge
//     resetn  : asynchronous active-low reset
//     bus     : seg7_word_reader_if.slave (glyph stream in, word out)
//   Parameters:
//     NUM_DIGITS : glyphs per word, 1..8
//   Build option:
//     SEG7_BLANK_EN : when defined, the all-off glyph 7'h7F is accepted as a
//                     blanked digit (nibble 0, no error).
module seg7_word_reader #(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                clock,
  input  logic                resetn,
  seg7_word_reader_if.slave   bus
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t       state, state_nx;
  logic [W-1:0] shift, shift_nx;
  logic [W-1:0] value_q;
  logic         err_q;
  logic         sticky;
  logic [3:0]   cnt;
  logic [3:0]   nib;
  logic         illegal;
  logic         accept;
  logic         last;

  always_comb begin
    nib     = '0;
    illegal = 1'b0;
    case (bus.seg_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
`ifdef SEG7_BLANK_EN
      7'h7F: nib = 4'h0;
`endif
      default: illegal = 1'b1;
    endcase
  end

  // flush wins over seg_valid, so a flushed glyph is never accepted
  assign accept   = (state == COLLECT) && bus.seg_valid && !bus.flush;
  assign last     = (cnt == 4'(NUM_DIGITS - 1));
  // shift-then-or keeps NUM_DIGITS=1 legal (no negative part-select)
  assign shift_nx = (shift << 4) | W'(nib);

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (accept && last) state_nx = HOLD;
      HOLD:    if (bus.value_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= COLLECT;
    else         state <= state_nx;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
      sticky  <= 1'b0;
      cnt     <= '0;
    end else if (state == COLLECT) begin
      if (bus.flush) begin
        shift  <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else if (bus.seg_valid) begin
        if (last) begin
          value_q <= shift_nx;
          err_q   <= sticky | illegal;
          shift   <= '0;
          cnt     <= '0;
          sticky  <= 1'b0;
        end else begin
          shift  <= shift_nx;
          cnt    <= cnt + 4'd1;
          sticky <= sticky | illegal;
        end
      end
    end
  end

  assign bus.seg_ready   = (state == COLLECT);
  assign bus.value_valid = (state == HOLD);
  assign bus.value       = value_q;
  assign bus.value_err   = err_q;
  assign bus.digit_cnt   = cnt;

endmodule
